gate_vector_checker: RTL

- Downstream checking stage for the two-input gate bank (AND, OR, NAND, NOR, XOR, XNOR, NOT-a).
- Takes each applied input pair (a, b) and the seven observed gate outputs over a valid/ready handshake.
- Computes the expected outputs, compares them with the observed ones, and keeps pass/fail counts, input-pair coverage and the first failing vector.
- Session control is start → run → done. Intended as a self-checking sink in gate-level benches and FPGA smoke tests.

---
 rtl/gate_check_pkg.sv | 38 +++
 rtl/gate_vector_checker_if.sv | 28 ++
 rtl/gate_vector_checker.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/gate_check_pkg.sv
// Shared types and the reference gate model for the
// gate-bank vector checker.
package gate_check_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;

  localparam int AND_B  = 0;
  localparam int OR_B   = 1;
  localparam int NAND_B = 2;
  localparam int NOR_B  = 3;
  localparam int XOR_B  = 4;
  localparam int XNOR_B = 5;
  localparam int NOTA_B = 6;
  localparam int RES_W  = 7;

  // Expected gate-bank outputs for one input pair.
  function automatic logic [RES_W-1:0] gate_expected(
    input logic a,
    input logic b
  );
    logic [RES_W-1:0] e;
    e         = '0;
    e[AND_B]  = a & b;
    e[OR_B]   = a | b;
    e[NAND_B] = ~(a & b);
    e[NOR_B]  = ~(a | b);
    e[XOR_B]  = a ^ b;
    e[XNOR_B] = ~(a ^ b);
    e[NOTA_B] = ~a;
    return e;
  endfunction

endpackage

// File: rtl/gate_vector_checker_if.sv
// Vector handshake into the checker:
// applied pair plus observed gate outputs.
interface gate_vector_checker_if;
  import gate_check_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic             in_a;
  logic             in_b;
  logic [RES_W-1:0] in_res;

  modport master (
    output in_valid,
    output in_a,
    output in_b,
    output in_res,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_a,
    input  in_b,
    input  in_res,
    output in_ready
  );

endinterface

// File: rtl/gate_vector_checker.sv
// Two-stage checking sink for the gate bank:
// capture, compare, count, cover, log first failure.
module gate_vector_checker
  import gate_check_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int NUM_VECTORS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  gate_vector_checker_if.slave  vin,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      checked_cnt,
  output logic [CNT_W-1:0]      fail_cnt,
  output logic                  mismatch_pulse,
  output logic [3:0]            cover_mask,
  output logic                  first_fail_valid,
  output logic [15:0]           first_fail_info
);

  localparam logic [CNT_W-1:0] NV  = CNT_W'(NUM_VECTORS);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] MAX = '1;

  state_e           state_q;
  state_e           state_d;
  logic             sess_clr;
  logic [CNT_W-1:0] acc_q;
  logic             xfer;
  logic             acc_last;

  logic             valid1_q;
  logic             a_q;
  logic             b_q;
  logic [RES_W-1:0] res_q;
  logic [RES_W-1:0] exp_q;
  logic             mism;
  logic             ab_known;

  assign vin.in_ready = (state_q == RUN) && (acc_q < NV);
  assign xfer         = vin.in_valid && vin.in_ready;
  assign acc_last     = (acc_q == NV - ONE);

  assign busy = (state_q == RUN) || (state_q == DRAIN);
  assign done = (state_q == DONE);

  // Session sequencing and the start-edge clear strobe.
  always_comb begin
    state_d  = state_q;
    sess_clr = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = RUN;
          sess_clr = 1'b1;
        end
      end
      RUN: begin
        if (xfer && acc_last) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!valid1_q) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Accepted-vector counter, bounds in_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else if (sess_clr) begin
      acc_q <= '0;
    end else if (xfer) begin
      acc_q <= acc_q + ONE;
    end
  end

  // Stage 1: capture vector and precompute expected outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid1_q <= 1'b0;
      a_q      <= 1'b0;
      b_q      <= 1'b0;
      res_q    <= '0;
      exp_q    <= '0;
    end else begin
      valid1_q <= xfer;
      if (xfer) begin
        a_q   <= vin.in_a;
        b_q   <= vin.in_b;
        res_q <= vin.in_res;
        exp_q <= gate_expected(vin.in_a, vin.in_b);
      end
    end
  end

  // Case inequality so unknown observed bits count as failures.
  assign mism     = valid1_q && (res_q !== exp_q);
  assign ab_known = ((a_q ^ b_q) === 1'b0) ||
                    ((a_q ^ b_q) === 1'b1);

  // Stage 2: counters, coverage and first-failure capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      mismatch_pulse   <= 1'b0;
      checked_cnt      <= '0;
      fail_cnt         <= '0;
      cover_mask       <= '0;
      first_fail_valid <= 1'b0;
      first_fail_info  <= '0;
    end else begin
      mismatch_pulse <= mism;
      if (sess_clr) begin
        checked_cnt      <= '0;
        fail_cnt         <= '0;
        cover_mask       <= '0;
        first_fail_valid <= 1'b0;
        first_fail_info  <= '0;
      end else if (valid1_q) begin
        if (checked_cnt != MAX) begin
          checked_cnt <= checked_cnt + ONE;
        end
        if (ab_known) begin
          cover_mask[{a_q, b_q}] <= 1'b1;
        end
        if (mism) begin
          if (fail_cnt != MAX) begin
            fail_cnt <= fail_cnt + ONE;
          end
          if (!first_fail_valid) begin
            first_fail_valid <= 1'b1;
            first_fail_info  <= {a_q, b_q, res_q, exp_q};
          end
        end
      end
    end
  end

endmodule
